// File: rtl/direction_ctrl_pkg.sv
// Direction codes shared with the snake graphics/logic stage, plus the reversal helper.
package direction_ctrl_pkg;

  localparam logic [3:0] DIR_LEFT  = 4'b1000;
  localparam logic [3:0] DIR_RIGHT = 4'b0100;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0001;
  localparam logic [3:0] DIR_STOP  = 4'b0000;

  // Only ever called with one-hot codes; anything else maps to STOP.
  function automatic logic [3:0] opposite_dir(input logic [3:0] dir);
    logic [3:0] opp;
    case (dir)
      DIR_LEFT:  opp = DIR_RIGHT;
      DIR_RIGHT: opp = DIR_LEFT;
      DIR_UP:    opp = DIR_DOWN;
      DIR_DOWN:  opp = DIR_UP;
      default:   opp = DIR_STOP;
    endcase
    return opp;
  endfunction

endpackage

// File: rtl/direction_ctrl_btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and rising-edge detect for one raw button.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level only follows the synced input after it disagrees for DEB_CYCLES cycles in a row.
  always_comb begin
    sync1_d      = raw;
    sync2_d      = sync1_q;
    level_prev_d = level_q;
    level_d      = level_q;
    cnt_d        = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      cnt_q        <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/direction_ctrl.sv
// direction_ctrl: debounced buttons -> one-hot snake direction with reversal rejection and game-over freeze.
// Optional feature: define PAUSE_EN to add a debounced btn_pause input that blanks/restores the direction.
module direction_ctrl
  import direction_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       g_over,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
`ifdef PAUSE_EN
  input  logic       btn_pause,
`endif
  output logic [3:0] direction,
  output logic       dir_chg
);

  logic [3:0] raw_btn;
  logic [3:0] press_edge;
  logic [3:0] dir_q, dir_d;
  logic [3:0] direction_q, direction_d;
  logic       dir_chg_q, dir_chg_d;
  logic       single_press;
  logic       reversal;

  // Bit order matches the direction codes, so a single press edge is already the new code.
  assign raw_btn = {btn_left, btn_right, btn_up, btn_down};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_btn[i]),
      .level (),
      .press (press_edge[i])
    );
  end

`ifdef PAUSE_EN
  logic paused_q, paused_d;
  logic pause_edge;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_pause),
    .level (),
    .press (pause_edge)
  );
`endif

  assign single_press = ($countones(press_edge) == 1);
  assign reversal     = (dir_q != DIR_STOP) && (press_edge == opposite_dir(dir_q));

  // dir_q is the last accepted heading; the output is blanked separately while paused.
  always_comb begin
    dir_d = dir_q;
`ifdef PAUSE_EN
    paused_d = paused_q;
    if (g_over) begin
      dir_d    = DIR_STOP;
      paused_d = 1'b0;
    end else if (en) begin
      if (pause_edge) begin
        paused_d = ~paused_q;
      end else if (!paused_q && single_press && !reversal) begin
        dir_d = press_edge;
      end
    end
    direction_d = paused_d ? DIR_STOP : dir_d;
`else
    if (g_over) begin
      dir_d = DIR_STOP;
    end else if (en && single_press && !reversal) begin
      dir_d = press_edge;
    end
    direction_d = dir_d;
`endif
    dir_chg_d = (direction_d != direction_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q       <= DIR_STOP;
      direction_q <= DIR_STOP;
      dir_chg_q   <= 1'b0;
    end else begin
      dir_q       <= dir_d;
      direction_q <= direction_d;
      dir_chg_q   <= dir_chg_d;
    end
  end

`ifdef PAUSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paused_q <= 1'b0;
    end else begin
      paused_q <= paused_d;
    end
  end
`endif

  assign direction = direction_q;
  assign dir_chg   = dir_chg_q;

endmodule

// File: tb/tb_direction_ctrl.sv
// Directed self-checking bench for direction_ctrl with DEB_CYCLES=4, CNT_W=3 (PAUSE_EN steps when defined).
module tb_direction_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       g_over = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
`ifdef PAUSE_EN
  logic       btn_pause = 1'b0;
`endif
  logic [3:0] direction;
  logic       dir_chg;

  int passCount = 0;
  int checkCount = 0;
  int pulseTotal = 0;
  int pulses;
  int startPulses;

  direction_ctrl #(.DEB_CYCLES(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .g_over    (g_over),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
`ifdef PAUSE_EN
    .btn_pause (btn_pause),
`endif
    .direction (direction),
    .dir_chg   (dir_chg)
  );

  always #5 clk = ~clk;

  // dir_chg is registered, so the falling edge sees each high cycle exactly once.
  always @(negedge clk) begin
    if (dir_chg) pulseTotal <= pulseTotal + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setButtons(input logic [3:0] btns);
    btn_left  = btns[3];
    btn_right = btns[2];
    btn_up    = btns[1];
    btn_down  = btns[0];
  endtask

  // Press the given buttons for 10 cycles, release, let the release debounce settle, report dir_chg pulses.
  task automatic applyStimulus(input logic [3:0] btns, output int nPulses);
    int base;
    @(negedge clk);
    base = pulseTotal;
    setButtons(btns);
    waitCycles(10);
    @(negedge clk);
    setButtons(4'b0000);
    waitCycles(10);
    @(negedge clk);
    nPulses = pulseTotal - base;
  endtask

`ifdef PAUSE_EN
  task automatic pressPause(output int nPulses);
    int base;
    @(negedge clk);
    base = pulseTotal;
    btn_pause = 1'b1;
    waitCycles(10);
    @(negedge clk);
    btn_pause = 1'b0;
    waitCycles(10);
    @(negedge clk);
    nPulses = pulseTotal - base;
  endtask
`endif

  initial begin
    en = 1'b1;
    waitCycles(3);
    checkOutput("reset_direction", 32'(direction), 32'h0);
    checkOutput("reset_dir_chg", 32'(dir_chg), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(2);

    // Step 1: exact latency of a clean press.
    @(negedge clk);
    startPulses = pulseTotal;
    btn_right = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      waitCycles(1);
      if (i == 6) checkOutput("lat_before_clk7", 32'(direction), 32'h0);
      if (i == 6) checkOutput("lat_chg_before_clk7", 32'(dir_chg), 32'h0);
      if (i == 7) checkOutput("lat_dir_clk7", 32'(direction), 32'h4);
      if (i == 7) checkOutput("lat_chg_clk7", 32'(dir_chg), 32'h1);
      if (i == 8) checkOutput("lat_chg_clk8", 32'(dir_chg), 32'h0);
    end
    @(negedge clk);
    btn_right = 1'b0;
    waitCycles(10);
    @(negedge clk);
    checkOutput("held_right_one_pulse", 32'(pulseTotal - startPulses), 32'h1);

    // Step 2: reversal rejected, perpendicular accepted.
    applyStimulus(4'b1000, pulses);
    checkOutput("reverse_dir", 32'(direction), 32'h4);
    checkOutput("reverse_pulses", 32'(pulses), 32'h0);
    applyStimulus(4'b0010, pulses);
    checkOutput("up_dir", 32'(direction), 32'h2);
    checkOutput("up_pulses", 32'(pulses), 32'h1);
    applyStimulus(4'b0010, pulses);
    checkOutput("same_dir", 32'(direction), 32'h2);
    checkOutput("same_pulses", 32'(pulses), 32'h0);

    // Step 3: short glitch and simultaneous presses.
    @(negedge clk);
    startPulses = pulseTotal;
    btn_down = 1'b1;
    waitCycles(3);
    @(negedge clk);
    btn_down = 1'b0;
    waitCycles(12);
    checkOutput("glitch_dir", 32'(direction), 32'h2);
    checkOutput("glitch_pulses", 32'(pulseTotal - startPulses), 32'h0);
    applyStimulus(4'b0100, pulses);
    applyStimulus(4'b0001, pulses);
    checkOutput("down_dir", 32'(direction), 32'h1);
    applyStimulus(4'b1010, pulses);
    checkOutput("multi_dir", 32'(direction), 32'h1);
    checkOutput("multi_pulses", 32'(pulses), 32'h0);
    applyStimulus(4'b1000, pulses);
    checkOutput("left_dir", 32'(direction), 32'h8);

    // Step 4: game over freezes at STOP until reset.
    @(negedge clk);
    g_over = 1'b1;
    waitCycles(1);
    checkOutput("gover_dir", 32'(direction), 32'h0);
    checkOutput("gover_chg", 32'(dir_chg), 32'h1);
    waitCycles(1);
    checkOutput("gover_chg_once", 32'(dir_chg), 32'h0);
    applyStimulus(4'b0010, pulses);
    checkOutput("gover_press_dir", 32'(direction), 32'h0);
    checkOutput("gover_press_pulses", 32'(pulses), 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    g_over = 1'b0;
    #1;
    checkOutput("gover_reset_dir", 32'(direction), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a debounce leaves no stale event.
    @(negedge clk);
    startPulses = pulseTotal;
    btn_up = 1'b1;
    waitCycles(4);
    @(negedge clk);
    rst_n = 1'b0;
    btn_up = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(12);
    checkOutput("midreset_dir", 32'(direction), 32'h0);
    checkOutput("midreset_pulses", 32'(pulseTotal - startPulses), 32'h0);

    // Step 5: presses while disabled are lost, even if still held when re-enabled.
    @(negedge clk);
    startPulses = pulseTotal;
    en = 1'b0;
    btn_up = 1'b1;
    waitCycles(10);
    checkOutput("disabled_dir", 32'(direction), 32'h0);
    @(negedge clk);
    en = 1'b1;
    waitCycles(6);
    checkOutput("reenable_held_dir", 32'(direction), 32'h0);
    checkOutput("reenable_held_pulses", 32'(pulseTotal - startPulses), 32'h0);
    @(negedge clk);
    btn_up = 1'b0;
    waitCycles(10);
    applyStimulus(4'b0010, pulses);
    checkOutput("repress_dir", 32'(direction), 32'h2);
    checkOutput("repress_pulses", 32'(pulses), 32'h1);

`ifdef PAUSE_EN
    // Step 6: pause blanks the output, blocks presses and restores the heading.
    pressPause(pulses);
    checkOutput("pause_dir", 32'(direction), 32'h0);
    checkOutput("pause_pulses", 32'(pulses), 32'h1);
    applyStimulus(4'b1000, pulses);
    checkOutput("paused_press_dir", 32'(direction), 32'h0);
    checkOutput("paused_press_pulses", 32'(pulses), 32'h0);
    pressPause(pulses);
    checkOutput("resume_dir", 32'(direction), 32'h2);
    checkOutput("resume_pulses", 32'(pulses), 32'h1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
